// File: rtl/lcms_pkg.sv
// Shared constants and FIFO entry layout for the DAC loopback monitor.
package lcms_pkg;

    localparam int unsigned FRAME_BITS_DEF = 24;

    // DAC frame fields, MSB first on the wire
    localparam int unsigned CMD_MSB  = 23;
    localparam int unsigned CMD_LSB  = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned CMD_W    = CMD_MSB - CMD_LSB + 1;
    localparam int unsigned DATA_W   = DATA_MSB - DATA_LSB + 1;
    localparam int unsigned RSVD_W   = 16 - 1 - CMD_W;

    localparam logic CHAN_DAC1 = 1'b0;
    localparam logic CHAN_DAC2 = 1'b1;

    typedef struct packed {
        logic              chan;
        logic [RSVD_W-1:0] rsvd;
        logic [CMD_W-1:0]  cmd;
    } frame_hdr_t;

    typedef struct packed {
        frame_hdr_t        hdr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic fifo_entry_t make_entry(input logic              chan,
                                               input logic [CMD_W-1:0]  cmd,
                                               input logic [DATA_W-1:0] data);
        fifo_entry_t e;
        e.hdr.chan = chan;
        e.hdr.rsvd = '0;
        e.hdr.cmd  = cmd;
        e.data     = data;
        return e;
    endfunction

endpackage

// File: rtl/dac_frame_deser.sv
// Per-channel deserialiser: collects one SYNC-framed word from already synchronised
// SCLK/SYNC/DIN levels and reports it with a one-cycle done strobe.
module dac_frame_deser
    import lcms_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                  s_clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  sclk,
    input  logic                  sync,
    input  logic                  din,
    output logic                  done,
    output logic                  ok,
    output logic [FRAME_BITS-1:0] frame
);

    localparam int unsigned CNT_BITS = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(FRAME_BITS + 1);
    localparam logic [CNT_BITS-1:0] CNT_GOOD = CNT_BITS'(FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } deser_state_t;

    deser_state_t          state_q;
    logic                  sclk_d_q;
    logic                  sync_d_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [FRAME_BITS-1:0] sh_q;

    logic                  sclk_fall_c;
    logic                  sync_fall_c;
    logic                  sync_rise_c;
    logic [CNT_BITS-1:0]   cnt_nxt_c;
    logic [FRAME_BITS-1:0] sh_nxt_c;

    // Next shift/count values so a SCLK fall coinciding with the SYNC rise is still counted
    always_comb begin
        sclk_fall_c = sclk_d_q & ~sclk;
        sync_fall_c = sync_d_q & ~sync;
        sync_rise_c = ~sync_d_q & sync;
        cnt_nxt_c   = cnt_q;
        sh_nxt_c    = sh_q;
        if (sclk_fall_c) begin
            sh_nxt_c = {sh_q[FRAME_BITS-2:0], din};
            if (cnt_q != CNT_MAX) begin
                cnt_nxt_c = cnt_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge s_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sclk_d_q <= 1'b0;
            sync_d_q <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            done     <= 1'b0;
            ok       <= 1'b0;
            frame    <= '0;
        end else begin
            sclk_d_q <= sclk;
            sync_d_q <= sync;
            done     <= 1'b0;
            if (clr) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                sh_q    <= '0;
                ok      <= 1'b0;
                frame   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sync_fall_c) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        cnt_q <= cnt_nxt_c;
                        sh_q  <= sh_nxt_c;
                        if (sync_rise_c) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                            ok      <= (cnt_nxt_c == CNT_GOOD);
                            frame   <= sh_nxt_c;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/dac_frame_monitor.sv
// Snoops the DAC1/DAC2 serial links, queues every well-formed frame and serves it
// to the host as header/data 16-bit words on the pipe-out.
module dac_frame_monitor
    import lcms_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             s_clk,
    input  logic             reset_n,
    input  logic             ti_rst_soft,
    input  logic             DAC_SCLK,
    input  logic             DAC1_SYNC,
    input  logic             DAC1_DIN,
    input  logic             DAC2_SYNC,
    input  logic             DAC2_DIN,
    input  logic             ti_out_data_en,
    output logic [15:0]      ti_out_data,
    output logic [15:0]      ti_out_available,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned IN_W  = 5;

    logic [IN_W-1:0] pin_c;
    logic [IN_W-1:0] meta_q;
    logic [IN_W-1:0] sync_q;

    assign pin_c = {DAC_SCLK, DAC1_SYNC, DAC1_DIN, DAC2_SYNC, DAC2_DIN};

    // Two-flop synchronisers; reset low so a frame in flight at reset is never mistaken for a SYNC fall
    always_ff @(posedge s_clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= pin_c;
            sync_q <= meta_q;
        end
    end

    logic                  d1_done, d1_ok, d2_done, d2_ok;
    logic [FRAME_BITS-1:0] d1_frame, d2_frame;

    dac_frame_deser #(.FRAME_BITS(FRAME_BITS)) u_deser_dac1 (
        .s_clk   (s_clk),
        .reset_n (reset_n),
        .clr     (ti_rst_soft),
        .sclk    (sync_q[4]),
        .sync    (sync_q[3]),
        .din     (sync_q[2]),
        .done    (d1_done),
        .ok      (d1_ok),
        .frame   (d1_frame)
    );

    dac_frame_deser #(.FRAME_BITS(FRAME_BITS)) u_deser_dac2 (
        .s_clk   (s_clk),
        .reset_n (reset_n),
        .clr     (ti_rst_soft),
        .sclk    (sync_q[4]),
        .sync    (sync_q[1]),
        .din     (sync_q[0]),
        .done    (d2_done),
        .ok      (d2_ok),
        .frame   (d2_frame)
    );

    fifo_entry_t entry1_c, entry2_c;

    assign entry1_c = make_entry(CHAN_DAC1, CMD_W'(d1_frame[FRAME_BITS-1:CMD_LSB]),
                                 d1_frame[DATA_MSB:DATA_LSB]);
    assign entry2_c = make_entry(CHAN_DAC2, CMD_W'(d2_frame[FRAME_BITS-1:CMD_LSB]),
                                 d2_frame[DATA_MSB:DATA_LSB]);

    logic        d1_valid_c, d2_valid_c;
    logic        push_c;
    logic        pend_load_c;
    fifo_entry_t push_entry_c;
    logic        pend_v_q;
    fifo_entry_t pend_q;

    // One push per cycle: DAC1 first, then a parked DAC2 frame, then a fresh DAC2 frame
    always_comb begin
        d1_valid_c   = d1_done && d1_ok;
        d2_valid_c   = d2_done && d2_ok;
        push_c       = 1'b0;
        push_entry_c = '0;
        pend_load_c  = 1'b0;
        if (d1_valid_c) begin
            push_c       = 1'b1;
            push_entry_c = entry1_c;
            pend_load_c  = d2_valid_c;
        end else if (pend_v_q) begin
            push_c       = 1'b1;
            push_entry_c = pend_q;
            pend_load_c  = d2_valid_c;
        end else if (d2_valid_c) begin
            push_c       = 1'b1;
            push_entry_c = entry2_c;
        end
    end

    fifo_entry_t      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             half_q;

    logic             full_c, empty_c, wr_en_c, rd_c, pop_c, half_nxt_c;
    logic [OCC_W-1:0] occ_nxt_c;
    logic [15:0]      avail_nxt_c;
    logic [1:0]       err_inc_c;
    logic [SUM_W-1:0] err_sum_c, ovf_sum_c;
    fifo_entry_t      rd_entry_c;

    // Occupancy bookkeeping; full is evaluated on the pre-pop occupancy
    always_comb begin
        full_c      = (occ_q == OCC_W'(FIFO_DEPTH));
        empty_c     = (occ_q == '0);
        wr_en_c     = push_c && !full_c;
        rd_c        = ti_out_data_en && !empty_c;
        pop_c       = rd_c && half_q;
        half_nxt_c  = rd_c ? !half_q : half_q;
        occ_nxt_c   = occ_q + OCC_W'(wr_en_c) - OCC_W'(pop_c);
        avail_nxt_c = (16'(occ_nxt_c) << 1) - 16'(half_nxt_c);
        err_inc_c   = 2'(d1_done && !d1_ok) + 2'(d2_done && !d2_ok);
        err_sum_c   = {1'b0, frame_err_cnt} + SUM_W'(err_inc_c);
        ovf_sum_c   = {1'b0, ovf_cnt} + SUM_W'(push_c && full_c);
        rd_entry_c  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge s_clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= push_entry_c;
        end
    end

    always_ff @(posedge s_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            half_q           <= 1'b0;
            pend_v_q         <= 1'b0;
            pend_q           <= '0;
            ti_out_data      <= '0;
            ti_out_available <= '0;
            frame_err_cnt    <= '0;
            ovf_cnt          <= '0;
            underflow        <= 1'b0;
        end else if (ti_rst_soft) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            half_q           <= 1'b0;
            pend_v_q         <= 1'b0;
            pend_q           <= '0;
            ti_out_data      <= '0;
            ti_out_available <= '0;
            frame_err_cnt    <= '0;
            ovf_cnt          <= '0;
            underflow        <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q            <= occ_nxt_c;
            half_q           <= half_nxt_c;
            ti_out_available <= avail_nxt_c;

            if (pend_load_c) begin
                pend_v_q <= 1'b1;
                pend_q   <= entry2_c;
            end else if (pend_v_q && !d1_valid_c) begin
                pend_v_q <= 1'b0;
            end

            frame_err_cnt <= err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
            ovf_cnt       <= ovf_sum_c[CNT_W] ? '1 : ovf_sum_c[CNT_W-1:0];

            if (ti_out_data_en) begin
                if (empty_c) begin
                    ti_out_data <= '0;
                    underflow   <= 1'b1;
                end else begin
                    ti_out_data <= half_q ? rd_entry_c.data : rd_entry_c.hdr;
                end
            end
        end
    end

endmodule
